// File: rtl/ram_access_ctrl.sv
// Request sequencer in front of the data RAM / SFR block: turns one byte, bit or
// read-modify-write request at a time into ordered single-cycle rd/wr strobes.
module ram_access_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [7:0]               req_data,
  input  logic                     req_bit,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [7:0]               resp_data,
  output logic                     resp_bit,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic                     mem_is_bit,
  output logic [7:0]               mem_in_data,
  output logic                     mem_in_bit,
  input  logic [7:0]               mem_out,
  input  logic                     mem_out_bit
);

  localparam int unsigned DATA_WIDTH = 8;

  localparam logic [2:0] OP_RDB   = 3'b000;
  localparam logic [2:0] OP_WRB   = 3'b001;
  localparam logic [2:0] OP_RDBIT = 3'b010;
  localparam logic [2:0] OP_WRBIT = 3'b011;
  localparam logic [2:0] OP_INC   = 3'b100;
  localparam logic [2:0] OP_DEC   = 3'b101;
  localparam logic [2:0] OP_CPL   = 3'b110;
  localparam logic [2:0] OP_RSV   = 3'b111;

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} state_t;

  state_t                   state, state_nxt;
  logic [2:0]               op_q;
  logic                     accept;

  logic [ADDRESS_WIDTH-1:0] mem_addr_nxt;
  logic                     mem_rd_nxt, mem_wr_nxt, mem_is_bit_nxt, mem_in_bit_nxt;
  logic [DATA_WIDTH-1:0]    mem_in_data_nxt, resp_data_nxt;
  logic                     resp_valid_nxt, resp_bit_nxt, resp_err_nxt;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_nxt       = state;
    mem_rd_nxt      = 1'b0;
    mem_wr_nxt      = 1'b0;
    mem_addr_nxt    = mem_addr;
    mem_is_bit_nxt  = mem_is_bit;
    mem_in_data_nxt = mem_in_data;
    mem_in_bit_nxt  = mem_in_bit;
    resp_valid_nxt  = resp_valid;
    resp_data_nxt   = resp_data;
    resp_bit_nxt    = resp_bit;
    resp_err_nxt    = resp_err;

    case (state)
      IDLE: begin
        if (req_valid) begin
          resp_err_nxt = 1'b0;
          case (req_op)
            OP_WRB, OP_WRBIT: begin
              state_nxt       = WRITE;
              mem_wr_nxt      = 1'b1;
              mem_addr_nxt    = req_addr;
              mem_is_bit_nxt  = (req_op == OP_WRBIT);
              mem_in_data_nxt = req_data;
              mem_in_bit_nxt  = req_bit;
              resp_data_nxt   = req_data;
              resp_bit_nxt    = req_bit;
            end
            OP_RSV: begin
              state_nxt      = DONE;
              resp_valid_nxt = 1'b1;
              resp_err_nxt   = 1'b1;
            end
            default: begin
              state_nxt      = READ;
              mem_rd_nxt     = 1'b1;
              mem_addr_nxt   = req_addr;
              mem_is_bit_nxt = (req_op == OP_RDBIT) || (req_op == OP_CPL);
            end
          endcase
        end
      end
      READ: state_nxt = CAPT;
      CAPT: begin
        // Response always reports the value before modification
        resp_data_nxt = mem_out;
        resp_bit_nxt  = mem_out_bit;
        case (op_q)
          OP_INC: begin
            state_nxt       = WRITE;
            mem_wr_nxt      = 1'b1;
            mem_in_data_nxt = mem_out + DATA_WIDTH'(1);
          end
          OP_DEC: begin
            state_nxt       = WRITE;
            mem_wr_nxt      = 1'b1;
            mem_in_data_nxt = mem_out - DATA_WIDTH'(1);
          end
          OP_CPL: begin
            state_nxt      = WRITE;
            mem_wr_nxt     = 1'b1;
            mem_in_bit_nxt = ~mem_out_bit;
          end
          default: begin
            state_nxt      = DONE;
            resp_valid_nxt = 1'b1;
          end
        endcase
      end
      WRITE: begin
        state_nxt      = DONE;
        resp_valid_nxt = 1'b1;
      end
      DONE: begin
        if (resp_ready) begin
          state_nxt      = IDLE;
          resp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs and latched opcode
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q        <= OP_RDB;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_is_bit  <= 1'b0;
      mem_in_data <= '0;
      mem_in_bit  <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_bit    <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      if (accept) op_q <= req_op;
      mem_addr    <= mem_addr_nxt;
      mem_rd      <= mem_rd_nxt;
      mem_wr      <= mem_wr_nxt;
      mem_is_bit  <= mem_is_bit_nxt;
      mem_in_data <= mem_in_data_nxt;
      mem_in_bit  <= mem_in_bit_nxt;
      resp_valid  <= resp_valid_nxt;
      resp_data   <= resp_data_nxt;
      resp_bit    <= resp_bit_nxt;
      resp_err    <= resp_err_nxt;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a small behavioural RAM and a
// response scoreboard queue.
module tb_ram_access_ctrl;

  localparam logic [2:0] OP_RDB   = 3'b000;
  localparam logic [2:0] OP_WRB   = 3'b001;
  localparam logic [2:0] OP_RDBIT = 3'b010;
  localparam logic [2:0] OP_WRBIT = 3'b011;
  localparam logic [2:0] OP_INC   = 3'b100;
  localparam logic [2:0] OP_DEC   = 3'b101;
  localparam logic [2:0] OP_CPL   = 3'b110;
  localparam logic [2:0] OP_RSV   = 3'b111;

  typedef struct packed {
    logic       chk_data;
    logic [7:0] data;
    logic       chk_bit;
    logic       b;
    logic       err;
  } resp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_bit;
  logic [2:0] req_op;
  logic [7:0] req_addr, req_data;
  logic       resp_valid, resp_ready, resp_bit, resp_err;
  logic [7:0] resp_data;
  logic [7:0] mem_addr, mem_in_data, mem_out;
  logic       mem_rd, mem_wr, mem_is_bit, mem_in_bit, mem_out_bit;

  logic [7:0] ram [256];
  resp_t      sb [$];
  int         n_pass = 0;
  int         n_total = 0;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  logic [7:0] exp_addr = 8'h00;
  logic       exp_is_bit = 1'b0;
  logic [7:0] exp_wdata = 8'h00;
  logic       exp_wbit = 1'b0;

  ram_access_ctrl #(.ADDRESS_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .req_bit(req_bit),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_bit(resp_bit), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_is_bit(mem_is_bit),
    .mem_in_data(mem_in_data), .mem_in_bit(mem_in_bit),
    .mem_out(mem_out), .mem_out_bit(mem_out_bit)
  );

  always #5 clock = ~clock;

  // 8051-style bit address: 00-7F map to bytes 20-2F, 80-FF to SFR bytes x0/x8
  function automatic logic [7:0] bit_byte(input logic [7:0] a);
    return a[7] ? {a[7:3], 3'b000} : 8'h20 + 8'(a[6:3]);
  endfunction

  always @(posedge clock) begin
    if (mem_rd) begin
      mem_out     <= ram[mem_addr];
      mem_out_bit <= ram[bit_byte(mem_addr)][mem_addr[2:0]];
    end
    if (mem_wr) begin
      if (mem_is_bit) ram[bit_byte(mem_addr)][mem_addr[2:0]] <= mem_in_bit;
      else            ram[mem_addr] <= mem_in_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Strobe monitor: exclusivity, address/bit-mode and write data
  always @(negedge clock) begin
    if (mem_rd || mem_wr) begin
      check("strobe_excl", 32'(mem_rd & mem_wr), 32'd0);
      check("strobe_addr", 32'(mem_addr), 32'(exp_addr));
      check("strobe_is_bit", 32'(mem_is_bit), 32'(exp_is_bit));
      if (mem_rd) rd_cnt++;
      if (mem_wr) begin
        wr_cnt++;
        if (exp_is_bit) check("wr_bit", 32'(mem_in_bit), 32'(exp_wbit));
        else            check("wr_data", 32'(mem_in_data), 32'(exp_wdata));
      end
    end
  end

  function automatic resp_t mk(input logic cd, input logic [7:0] d, input logic cb,
                               input logic b, input logic e);
    resp_t r;
    r.chk_data = cd; r.data = d; r.chk_bit = cb; r.b = b; r.err = e;
    return r;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d,
                       input logic b);
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d; req_bit = b;
  endtask

  // Returns at the negedge of the cycle after the accept edge
  task automatic wait_accept(input string tag);
    int n = 0;
    while (!req_ready && n < 100) begin @(negedge clock); n++; end
    if (!req_ready) check({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int lat);
    int cyc = 1;
    while (!resp_valid && cyc < 20) begin @(negedge clock); cyc++; end
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
  endtask

  task automatic take_resp(input string tag);
    resp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_data) check({tag, "_resp_data"}, 32'(resp_data), 32'(e.data));
      if (e.chk_bit)  check({tag, "_resp_bit"}, 32'(resp_bit), 32'(e.b));
      check({tag, "_resp_err"}, 32'(resp_err), 32'(e.err));
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic op_run(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] d, input logic b, input int lat, input int nrd,
                        input int nwr, input resp_t e, input logic [7:0] wd, input logic wb);
    int rd0;
    int wr0;
    @(negedge clock);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    exp_addr   = a;
    exp_is_bit = (op == OP_RDBIT) || (op == OP_WRBIT) || (op == OP_CPL);
    exp_wdata  = wd;
    exp_wbit   = wb;
    sb.push_back(e);
    drive(op, a, d, b);
    wait_accept(tag);
    wait_resp(tag, lat);
    take_resp(tag);
    check({tag, "_rd_pulses"}, 32'(rd_cnt - rd0), 32'(nrd));
    check({tag, "_wr_pulses"}, 32'(wr_cnt - wr0), 32'(nwr));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_data"}, 32'(resp_data), 32'd0);
    check({tag, "_resp_bit"}, 32'(resp_bit), 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    check({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
    check({tag, "_mem_is_bit"}, 32'(mem_is_bit), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_in_data"}, 32'(mem_in_data), 32'd0);
    check({tag, "_mem_in_bit"}, 32'(mem_in_bit), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd0;
    int wr0;
    reset = 1'b1; req_valid = 1'b0; req_op = OP_RDB; req_addr = 8'h00;
    req_data = 8'h00; req_bit = 1'b0; resp_ready = 1'b1;
    #2 reset = 1'b0;
    #2 check_reset_vals("reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Byte write then read back
    op_run("wrb30", OP_WRB, 8'h30, 8'hA5, 1'b0, 2, 0, 1, mk(1, 8'hA5, 1, 0, 0), 8'hA5, 1'b0);
    op_run("rdb30", OP_RDB, 8'h30, 8'h00, 1'b0, 3, 1, 0, mk(1, 8'hA5, 0, 0, 0), 8'h00, 1'b0);

    // INC wraps FF->00, DEC wraps 00->FF; response is the old value
    op_run("wrb40", OP_WRB, 8'h40, 8'hFF, 1'b0, 2, 0, 1, mk(1, 8'hFF, 1, 0, 0), 8'hFF, 1'b0);
    op_run("inc40", OP_INC, 8'h40, 8'h00, 1'b0, 4, 1, 1, mk(1, 8'hFF, 0, 0, 0), 8'h00, 1'b0);
    op_run("rdb40", OP_RDB, 8'h40, 8'h00, 1'b0, 3, 1, 0, mk(1, 8'h00, 0, 0, 0), 8'h00, 1'b0);
    op_run("wrb41", OP_WRB, 8'h41, 8'h00, 1'b0, 2, 0, 1, mk(1, 8'h00, 1, 0, 0), 8'h00, 1'b0);
    op_run("dec41", OP_DEC, 8'h41, 8'h00, 1'b0, 4, 1, 1, mk(1, 8'h00, 0, 0, 0), 8'hFF, 1'b0);
    op_run("rdb41", OP_RDB, 8'h41, 8'h00, 1'b0, 3, 1, 0, mk(1, 8'hFF, 0, 0, 0), 8'h00, 1'b0);

    // Bit write, complement, read
    op_run("wrbit0b", OP_WRBIT, 8'h0B, 8'h3C, 1'b1, 2, 0, 1, mk(1, 8'h3C, 1, 1, 0), 8'h00, 1'b1);
    op_run("cpl0b", OP_CPL, 8'h0B, 8'h00, 1'b0, 4, 1, 1, mk(0, 8'h00, 1, 1, 0), 8'h00, 1'b0);
    op_run("rdbit0b", OP_RDBIT, 8'h0B, 8'h00, 1'b0, 3, 1, 0, mk(0, 8'h00, 1, 0, 0), 8'h00, 1'b0);

    // Reserved opcode: error response at T+1, no strobes
    op_run("rsv", OP_RSV, 8'h55, 8'h00, 1'b0, 1, 0, 0, mk(0, 8'h00, 0, 0, 1), 8'h00, 1'b0);

    // Response back-pressure with a new request waiting upstream
    @(negedge clock);
    exp_addr = 8'h30; exp_is_bit = 1'b0;
    sb.push_back(mk(1, 8'hA5, 0, 0, 0));
    resp_ready = 1'b0;
    drive(OP_RDB, 8'h30, 8'h00, 1'b0);
    wait_accept("bp");
    wait_resp("bp", 3);
    drive(OP_WRB, 8'h31, 8'h5A, 1'b0);
    exp_addr = 8'h31; exp_wdata = 8'h5A;
    rd0 = rd_cnt; wr0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_data", 32'(resp_data), 32'hA5);
      check("bp_resp_err", 32'(resp_err), 32'd0);
      @(negedge clock);
    end
    check("bp_rd_pulses", 32'(rd_cnt - rd0), 32'd0);
    check("bp_wr_pulses", 32'(wr_cnt - wr0), 32'd0);
    resp_ready = 1'b1;
    take_resp("bp");
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_idle_valid", 32'(resp_valid), 32'd0);
    sb.push_back(mk(1, 8'h5A, 1, 0, 0));
    wait_accept("bp_next");
    wait_resp("bp_next", 2);
    take_resp("bp_next");
    check("bp_next_wr_pulses", 32'(wr_cnt - wr0), 32'd1);

    // Reset during CAPT of an INC: no write, response discarded
    op_run("wrb50", OP_WRB, 8'h50, 8'h10, 1'b0, 2, 0, 1, mk(1, 8'h10, 1, 0, 0), 8'h10, 1'b0);
    @(negedge clock);
    exp_addr = 8'h50; exp_is_bit = 1'b0; exp_wdata = 8'h11;
    wr0 = wr_cnt;
    drive(OP_INC, 8'h50, 8'h00, 1'b0);
    wait_accept("inc_rst");
    check("inc_rst_read_strobe", 32'(mem_rd), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    #1 check_reset_vals("rst_mid");
    @(negedge clock);
    drive(OP_RDB, 8'h50, 8'h00, 1'b0);
    sb.push_back(mk(1, 8'h10, 0, 0, 0));
    @(negedge clock);
    reset = 1'b1;
    wait_accept("rel");
    check("rel_read_strobe", 32'(mem_rd), 32'd1);
    wait_resp("rel", 3);
    take_resp("rel");
    check("rst_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("rst_sb_drained", 32'(sb.size()), 32'd0);

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
